// File: rtl/bcd_to_bin_seq.sv
// bcd_to_bin_seq: multi-cycle BCD-to-binary converter.
// Converts one BCD digit per clock, most-significant first, as acc = acc*10 + digit.
// Flags nibbles above 9 (still used at their raw value) and results exceeding BIN_W bits.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   input word present
//   in_ready   converter idle and able to accept a word
//   bcd        DIGITS*4-bit BCD word, digit 0 in bcd[3:0]
//   out_valid  result present
//   out_ready  consumer accepts result
//   bin        binary result, true value mod 2^BIN_W
//   err_digit  at least one nibble of the last word was > 9
//   overflow   true value of the last word exceeded 2^BIN_W-1
//   busy       converter is not idle
module bcd_to_bin_seq #(
    parameter int unsigned BIN_W  = 16,
    parameter int unsigned DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIGITS*4-1:0]   bcd,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BIN_W-1:0]      bin,
    output logic                  err_digit,
    output logic                  overflow,
    output logic                  busy
);

    localparam int unsigned CntW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

    state_e                 state_q, state_d;
    logic [DIGITS*4-1:0]    shreg_q;
    logic [BIN_W-1:0]       acc_q;
    logic [CntW-1:0]        cnt_q;
    logic                   err_acc_q;
    logic                   ovf_acc_q;
    logic [BIN_W-1:0]       bin_q;
    logic                   err_digit_q;
    logic                   overflow_q;

    logic                   accept;
    logic                   last_digit;
    logic [3:0]             digit;
    logic [BIN_W+3:0]       acc_ext;
    logic [BIN_W+3:0]       sum;
    logic                   digit_bad;
    logic                   step_ovf;

    assign accept     = (state_q == StIdle) && in_valid;
    assign last_digit = (state_q == StConv) && (cnt_q == '0);

    // One x10 as shift-add, plus the incoming digit; the 4 extra bits catch overflow.
    always_comb begin
        digit     = shreg_q[DIGITS*4-1 -: 4];
        acc_ext   = {4'b0000, acc_q};
        sum       = (acc_ext << 3) + (acc_ext << 1) + {{BIN_W{1'b0}}, digit};
        digit_bad = (digit > 4'd9);
        step_ovf  = (sum[BIN_W+3:BIN_W] != 4'b0000);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (in_valid)   state_d = StConv;
            StConv: if (last_digit) state_d = StDone;
            StDone: if (out_ready)  state_d = StIdle;
            default:                state_d = StIdle;
        endcase
    end

    // Output logic.
    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
        busy      = (state_q != StIdle);
        bin       = bin_q;
        err_digit = err_digit_q;
        overflow  = overflow_q;
    end

    // Datapath: working registers run during CONV; visible results load only on completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q     <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            err_acc_q   <= 1'b0;
            ovf_acc_q   <= 1'b0;
            bin_q       <= '0;
            err_digit_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else if (accept) begin
            shreg_q   <= bcd;
            acc_q     <= '0;
            cnt_q     <= CntW'(DIGITS - 1);
            err_acc_q <= 1'b0;
            ovf_acc_q <= 1'b0;
        end else if (state_q == StConv) begin
            shreg_q   <= shreg_q << 4;
            acc_q     <= sum[BIN_W-1:0];
            cnt_q     <= cnt_q - CntW'(1);
            err_acc_q <= err_acc_q | digit_bad;
            ovf_acc_q <= ovf_acc_q | step_ovf;
            if (last_digit) begin
                bin_q       <= sum[BIN_W-1:0];
                err_digit_q <= err_acc_q | digit_bad;
                overflow_q  <= ovf_acc_q | step_ovf;
            end
        end
    end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Self-checking bench for bcd_to_bin_seq: three instances (16b/5 digits, 8b/3 digits,
// 8b/1 digit) sharing clock and reset, driven by directed vectors.
module tb_bcd_to_bin_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  iv;
    logic [2:0]  ordy;
    logic [2:0]  ir;
    logic [2:0]  ov;
    logic [2:0]  err;
    logic [2:0]  ovf;
    logic [2:0]  bsy;
    logic [19:0] bcd0;
    logic [11:0] bcd1;
    logic [3:0]  bcd2;
    logic [15:0] bin0;
    logic [7:0]  bin1;
    logic [7:0]  bin2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    bcd_to_bin_seq #(.BIN_W(16), .DIGITS(5)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .bcd(bcd0),
        .out_valid(ov[0]), .out_ready(ordy[0]), .bin(bin0), .err_digit(err[0]),
        .overflow(ovf[0]), .busy(bsy[0])
    );

    bcd_to_bin_seq #(.BIN_W(8), .DIGITS(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .bcd(bcd1),
        .out_valid(ov[1]), .out_ready(ordy[1]), .bin(bin1), .err_digit(err[1]),
        .overflow(ovf[1]), .busy(bsy[1])
    );

    bcd_to_bin_seq #(.BIN_W(8), .DIGITS(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .bcd(bcd2),
        .out_valid(ov[2]), .out_ready(ordy[2]), .bin(bin2), .err_digit(err[2]),
        .overflow(ovf[2]), .busy(bsy[2])
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] got_bin(input int w);
        case (w)
            0:       return bin0;
            1:       return {8'h00, bin1};
            default: return {8'h00, bin2};
        endcase
    endfunction

    // Full conversion on instance w with out_ready low until the result is seen.
    task automatic convert(input int w, input logic [19:0] v, input logic [15:0] exp_bin,
                           input logic exp_err, input logic exp_ovf, input int exp_lat,
                           input string tag);
        int lat;
        @(negedge clk);
        bcd0  = v;
        bcd1  = v[11:0];
        bcd2  = v[3:0];
        iv[w] = 1'b1;
        check_eq({tag, ".in_ready"}, 32'(ir[w]), 32'd1);
        @(negedge clk);
        iv[w] = 1'b0;
        lat = 1;
        while (!ov[w] && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check_eq({tag, ".latency"}, 32'(lat - 1), 32'(exp_lat));
        check_eq({tag, ".bin"}, 32'(got_bin(w)), 32'(exp_bin));
        check_eq({tag, ".err_digit"}, 32'(err[w]), 32'(exp_err));
        check_eq({tag, ".overflow"}, 32'(ovf[w]), 32'(exp_ovf));
        ordy[w] = 1'b1;
        @(negedge clk);
        ordy[w] = 1'b0;
        check_eq({tag, ".out_valid_drop"}, 32'(ov[w]), 32'd0);
        check_eq({tag, ".bin_hold"}, 32'(got_bin(w)), 32'(exp_bin));
    endtask

    initial begin
        int lat;
        rst_n = 1'b0;
        iv    = '0;
        ordy  = '0;
        bcd0  = '0;
        bcd1  = '0;
        bcd2  = '0;
        #12;
        for (int w = 0; w < 3; w++) begin
            check_eq("rst.in_ready", 32'(ir[w]), 32'd1);
            check_eq("rst.out_valid", 32'(ov[w]), 32'd0);
            check_eq("rst.busy", 32'(bsy[w]), 32'd0);
            check_eq("rst.bin", 32'(got_bin(w)), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Default parameters: basic, overflow boundary, invalid digit.
        convert(0, 20'h12345, 16'h3039, 1'b0, 1'b0, 5, "basic");
        convert(0, 20'h65535, 16'hFFFF, 1'b0, 1'b0, 5, "max");
        convert(0, 20'h65536, 16'h0000, 1'b0, 1'b1, 5, "ovf_edge");
        convert(0, 20'h99999, 16'h869F, 1'b0, 1'b1, 5, "ovf_all9");
        convert(0, 20'h0A000, 16'h2710, 1'b1, 1'b0, 5, "bad_digit");
        convert(0, 20'h00007, 16'h0007, 1'b0, 1'b0, 5, "after_bad");

        // Backpressure with a competing word and changing bcd during CONV/DONE.
        @(negedge clk);
        bcd0  = 20'h00042;
        iv[0] = 1'b1;
        @(negedge clk);
        bcd0 = 20'h99999;
        lat  = 1;
        while (!ov[0] && lat < 20) begin
            check_eq("bp.conv_busy", 32'(bsy[0]), 32'd1);
            check_eq("bp.conv_in_ready", 32'(ir[0]), 32'd0);
            @(negedge clk);
            lat++;
        end
        check_eq("bp.latency", 32'(lat - 1), 32'd5);
        for (int i = 0; i < 3; i++) begin
            bcd0 = 20'(i * 20'h11111);
            check_eq("bp.out_valid", 32'(ov[0]), 32'd1);
            check_eq("bp.bin", 32'(bin0), 32'd42);
            check_eq("bp.err_digit", 32'(err[0]), 32'd0);
            check_eq("bp.overflow", 32'(ovf[0]), 32'd0);
            check_eq("bp.in_ready", 32'(ir[0]), 32'd0);
            check_eq("bp.busy", 32'(bsy[0]), 32'd1);
            @(negedge clk);
        end
        ordy[0] = 1'b1;
        iv[0]   = 1'b0;
        @(negedge clk);
        ordy[0] = 1'b0;
        check_eq("bp.out_valid_drop", 32'(ov[0]), 32'd0);
        check_eq("bp.in_ready_back", 32'(ir[0]), 32'd1);
        check_eq("bp.bin_hold", 32'(bin0), 32'd42);

        // Asynchronous reset two cycles into CONV.
        @(negedge clk);
        bcd0  = 20'h12345;
        iv[0] = 1'b1;
        @(negedge clk);
        iv[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("mid.busy_before", 32'(bsy[0]), 32'd1);
        #2;
        rst_n = 1'b0;
        iv[0] = 1'b1;
        #1;
        check_eq("mid.out_valid", 32'(ov[0]), 32'd0);
        check_eq("mid.busy", 32'(bsy[0]), 32'd0);
        check_eq("mid.in_ready", 32'(ir[0]), 32'd1);
        check_eq("mid.bin", 32'(bin0), 32'd0);
        @(negedge clk);
        check_eq("mid.held_idle", 32'(bsy[0]), 32'd0);
        rst_n = 1'b1;
        iv[0] = 1'b0;
        convert(0, 20'h00100, 16'd100, 1'b0, 1'b0, 5, "after_rst");

        // Alternate parameters.
        convert(1, 20'h00255, 16'h00FF, 1'b0, 1'b0, 3, "w8_max");
        convert(1, 20'h00256, 16'h0000, 1'b0, 1'b1, 3, "w8_ovf");
        convert(1, 20'h00999, 16'h00E7, 1'b0, 1'b1, 3, "w8_all9");
        convert(2, 20'h00009, 16'h0009, 1'b0, 1'b0, 1, "d1_nine");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/bcd_to_bin_seq.md
# bcd_to_bin_seq

Parametrised, multi-cycle BCD-to-binary converter with valid/ready handshakes on input and output. It converts one BCD digit per clock, most-significant digit first, using the accumulate form `acc = acc*10 + digit`. Unlike a single-cycle converter, it flags invalid BCD digits (>9) and binary overflow. It sits in the code-converter library between BCD sources (keypad, display, serial front ends) and binary datapaths that can tolerate a fixed multi-cycle latency in exchange for a single small multiplier-by-10.

## Interface
- BIN_W, 16, binary result width (≥4)
- DIGITS, 5, number of BCD digits in one input word (≥1)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input word present
- in_ready  out  1  converter can accept a word
- bcd  in  DIGITS*4  BCD word; digit 0 = bcd[3:0] = least-significant digit
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- bin  out  BIN_W  binary result, equal to the true value mod 2^BIN_W
- err_digit  out  1  at least one input nibble was > 9
- overflow  out  1  true value exceeded 2^BIN_W-1
- busy  out  1  converter is not in IDLE

## Operation
- FSM states: IDLE, CONV, DONE.
- **IDLE**
  - in_ready=1.
  - On in_valid&&in_ready: capture bcd into a shift register, clear acc, err_digit and overflow, load digit counter with DIGITS-1, go to CONV.
- **CONV**
  - Each cycle, process the most-significant remaining nibble d.
  - Compute the full-precision sum `s = acc*10 + d` in BIN_W+4 bits.
  - acc <= s[BIN_W-1:0].
  - overflow |= (s[BIN_W+3:BIN_W] != 0).
  - err_digit |= (d > 9).
  - Shift the register left by 4.
  - When the counter reaches 0 (after DIGITS digits), go to DONE.
- **Invalid nibbles**: an invalid nibble (0xA–0xF) is still used arithmetically at its raw value 10–15. Only the flag distinguishes it.
- **DONE**
  - out_valid=1.
  - bin, err_digit and overflow are stable.
  - On out_ready: go to IDLE.
- bin, err_digit and overflow keep the last result after the handshake, until the next conversion completes. They update only on the CONV→DONE transition; intermediate acc values are not visible on bin.
- in_ready is high only in IDLE. A new word is never accepted in CONV or DONE. The input side needs no skid buffer.
- bcd is sampled only on the accept edge. Later changes to bcd are ignored.
- busy = (state != IDLE).
- **Reset**: asynchronous, usable mid-conversion.
  - Forces IDLE and clears acc, bin, err_digit, overflow, the counter and the shift register.
  - Output values while rst_n is low: in_ready=1, out_valid=0, busy=0, all others 0.
  - in_valid is ignored while rst_n is low.

## Timing
- Accept on edge T. CONV occupies edges T+1 … T+DIGITS. out_valid is high from edge T+DIGITS.
- Latency is DIGITS cycles from accept to out_valid.
- With out_ready held high, DONE lasts 1 cycle and the next accept can occur at edge T+DIGITS+2. Minimum issue interval is DIGITS+2 cycles.
- out_ready low holds DONE indefinitely. Outputs stay constant throughout.
- If out_ready is already high when out_valid rises, the result transfers on the first DONE edge.
- in_valid is don't-care outside IDLE. The source must hold bcd/in_valid until in_ready.
- Critical path is one ×10 (shift-add, BIN_W+4 bits) plus a 4-bit add per cycle. Do not use a DIGITS-deep multiplier chain.

## Test plan
- **Basic conversion and latency** (defaults): accept bcd=0x12345 → out_valid exactly 5 cycles after accept; bin=0x3039; err_digit=0; overflow=0.
- **Overflow boundary** (defaults):
  - bcd=0x65535 → bin=0xFFFF, overflow=0.
  - bcd=0x65536 → bin=0x0000, overflow=1.
  - bcd=0x99999 → bin=0x869F, overflow=1.
- **Invalid digit** (defaults): bcd=0x0A000 → err_digit=1, bin=0x2710 (raw 10×1000), overflow=0. The next conversion of bcd=0x00007 → err_digit=0, bin=7.
- **Backpressure and handshake** (defaults):
  - Convert 0x00042 with out_ready low for 3 cycles → out_valid, bin=42 and flags stable; in_ready=0 and busy=1 throughout.
  - A competing in_valid and changing bcd during CONV/DONE are not accepted and do not alter the result.
  - After out_ready, out_valid drops the next cycle.
- **Reset mid-operation** (defaults): deassert rst_n asynchronously 2 cycles into CONV → immediately out_valid=0, busy=0, in_ready=1, bin=0. After release, a fresh conversion of 0x00100 gives bin=100 with normal latency.
- **Alternate parameters** (BIN_W=8, DIGITS=3):
  - bcd=0x255 → bin=0xFF, overflow=0, latency 3.
  - bcd=0x256 → bin=0x00, overflow=1.
  - bcd=0x999 → bin=0xE7, overflow=1.
  - Also run DIGITS=1 with bcd=0x9 → bin=9, latency 1.
